// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pkg
//  Brief    : Shared FIR types, width helpers and sign-magnitude conversions.
//  Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int MAXW     = 64;
    localparam int DEF_TAPS = 30;
    localparam int DEF_DW   = 16;
    localparam int DEF_CW   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_e;

    function automatic int addr_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    // Headroom of clog2(TAPS) bits lets TAPS full-scale products sum without overflow.
    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw - 1 + addr_width(taps);
    endfunction

    localparam int DEF_AW   = addr_width(DEF_TAPS);
    localparam int DEF_ACCW = acc_width(DEF_DW, DEF_CW, DEF_TAPS);

    // Sign-magnitude of width w (right-aligned) to two's complement; -0 maps to 0.
    function automatic logic signed [MAXW-1:0] sm2tc(input logic [MAXW-1:0] sm, input int w);
        logic [MAXW-1:0] mag;
        logic            neg;
        mag = sm & ((MAXW'(1) << (w - 1)) - MAXW'(1));
        neg = |(sm & (MAXW'(1) << (w - 1)));
        return neg ? -mag : mag;
    endfunction

    // Two's complement to {sign, |v|}.
    function automatic logic [MAXW:0] tc2sm(input logic signed [MAXW-1:0] v);
        logic [MAXW-1:0] mag;
        mag = v[MAXW-1] ? -v : v;
        return {v[MAXW-1], mag};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_mac_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_seq_if
//  Brief    : Sample handshake, coefficient write and result bus of the FIR.
//  Revision : 1.0 - initial release
// ============================================================================
interface fir_mac_seq_if #(
    parameter int TAPS = 30,
    parameter int DW   = 16,
    parameter int CW   = 16
) ();
    localparam int AW = fir_pkg::addr_width(TAPS);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sat;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/fir_sm_mult.sv
`default_nettype none
// ============================================================================
//  Module   : fir_sm_mult
//  Brief    : Combinational sign-magnitude x sign-magnitude multiplier with a
//             two's complement product.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_sm_mult
    import fir_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic        [DW-1:0]    a_i,
    input  logic        [CW-1:0]    b_i,
    output logic signed [DW+CW-2:0] p_o
);
    localparam int PW = DW + CW - 1;

    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_b;

    // Operand magnitudes stay below 2^(DW-1) and 2^(CW-1), so PW bits hold the exact product.
    assign w_a = PW'(sm2tc(MAXW'(a_i), DW));
    assign w_b = PW'(sm2tc(MAXW'(b_i), CW));
    assign p_o = w_a * w_b;

endmodule
`default_nettype wire

// File: rtl/fir_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_seq
//  Brief    : TAPS-tap FIR filter with one time-multiplexed MAC unit;
//             sign-magnitude samples, coefficients and result.
//             Optional macro FIR_MAC_SAT_EN: saturate the result instead of wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int TAPS = 30,
    parameter int DW   = 16,
    parameter int CW   = 16
) (
    input  logic         clk_slow,
    input  logic         rst,
    fir_mac_seq_if.slave bus
);
    localparam int AW   = addr_width(TAPS);
    localparam int PW   = DW + CW - 1;
    localparam int ACCW = acc_width(DW, CW, TAPS);

    localparam logic [AW-1:0] c_LAST   = AW'(TAPS - 1);
    localparam logic [AW:0]   c_TAPS_X = (AW + 1)'(TAPS);

    fir_state_e              state_q, state_d;
    logic        [AW-1:0]    k_q, k_d;
    logic        [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic                    out_valid_q, out_valid_d;
    logic        [DW-1:0]    out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;

    logic [DW-1:0] hist_q [TAPS];
    logic [CW-1:0] coef_q [TAPS];

    logic                   w_accept;
    logic                   w_coef_we;
    logic        [AW-1:0]   w_rd_idx;
    logic        [DW-1:0]   w_hist_rd;
    logic        [CW-1:0]   w_coef_rd;
    logic signed [PW-1:0]   w_prod;
    logic signed [MAXW-1:0] w_acc_ext;
    logic        [MAXW:0]   w_sm;
    logic        [DW-2:0]   w_mag;
    logic                   w_sign;
    logic                   w_sat;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    assign w_accept  = bus.in_valid && (state_q == IDLE);
    assign w_coef_we = bus.coef_we && (state_q == IDLE) && ({1'b0, bus.coef_addr} < c_TAPS_X);

    // Newest sample sits at wr_ptr; tap k reads k entries back, wrapping modulo TAPS.
    assign w_rd_idx  = (k_q <= wr_ptr_q) ? (wr_ptr_q - k_q)
                                         : AW'({1'b0, wr_ptr_q} + c_TAPS_X - {1'b0, k_q});
    assign w_hist_rd = hist_q[w_rd_idx];
    assign w_coef_rd = coef_q[k_q];

    fir_sm_mult #(
        .DW (DW),
        .CW (CW)
    ) u_mult (
        .a_i (w_hist_rd),
        .b_i (w_coef_rd),
        .p_o (w_prod)
    );

    assign w_acc_ext = {{(MAXW - ACCW){acc_q[ACCW-1]}}, acc_q};
    assign w_sm      = tc2sm(w_acc_ext);

`ifdef FIR_MAC_SAT_EN
    localparam logic [MAXW-1:0] c_MAXMAG = (MAXW'(1) << (DW - 1)) - MAXW'(1);
    logic [MAXW-1:0] w_mag_sh;
    assign w_mag_sh = w_sm[MAXW-1:0] >> (CW - 1);
    assign w_sat    = (w_mag_sh > c_MAXMAG);
    assign w_mag    = w_sat ? c_MAXMAG[DW-2:0] : w_mag_sh[DW-2:0];
`else
    assign w_sat    = 1'b0;
    assign w_mag    = (DW - 1)'(w_sm[MAXW-1:0] >> (CW - 1));
`endif

    // A magnitude that truncates to zero is reported as +0.
    assign w_sign = w_sm[MAXW] && (w_mag != '0);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        wr_ptr_d    = wr_ptr_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = MAC;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            MAC: begin
                acc_d = acc_q + {{(ACCW - PW){w_prod[PW-1]}}, w_prod};
                if (k_q == c_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                out_data_d  = {w_sign, w_mag};
                out_sat_d   = w_sat;
                wr_ptr_d    = (wr_ptr_q == c_LAST) ? '0 : wr_ptr_q + 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            wr_ptr_q    <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wr_ptr_q    <= wr_ptr_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                hist_q[wr_ptr_q] <= bus.in_data;
            end
            if (w_coef_we) begin
                coef_q[bus.coef_addr] <= bus.coef_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_mac_seq
//  Brief    : Directed, table-driven bench for fir_mac_seq (TAPS=30, DW=CW=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fir_mac_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fir_mac_seq_if #(.TAPS(30), .DW(16), .CW(16)) bus ();

    fir_mac_seq #(
        .TAPS (30),
        .DW   (16),
        .CW   (16)
    ) dut (
        .clk_slow (clk),
        .rst      (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp_out;
    } vec_t;

    vec_t tbl [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic write_coef(input logic [4:0] addr, input logic [15:0] data);
        bus.coef_we   = 1'b1;
        bus.coef_addr = addr;
        bus.coef_data = data;
        tick();
        bus.coef_we   = 1'b0;
    endtask

    // Push one sample (optionally with a coefficient write on the accept edge) and check the result.
    task automatic sample_check(input string name, input logic [15:0] din,
                                input logic [15:0] exp_d, input logic exp_s,
                                input bit with_cw, input logic [4:0] cw_a, input logic [15:0] cw_d);
        int n;
        bit seen;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = din;
        if (with_cw) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = cw_a;
            bus.coef_data = cw_d;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no out_valid within 40 cycles", name);
        end else begin
            check({name, " data"}, 32'(bus.out_data), 32'(exp_d));
            check({name, " sat"},  32'(bus.out_sat),  32'(exp_s));
        end
    endtask

    initial begin
        int          acc_e[$];
        int          out_e[$];
        logic [15:0] out_d[$];
        int          cnt;

        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;

        // Reset state
        #12;
        check("reset out_data",  32'(bus.out_data),  32'h0);
        check("reset out_valid", 32'(bus.out_valid), 32'h0);
        check("reset out_sat",   32'(bus.out_sat),   32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("reset in_ready", 32'(bus.in_ready), 32'h1);

        // Impulse through tap 1
        write_coef(5'd1, 16'h0040);
        sample_check("impulse0", 16'h7FFF, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0);
        sample_check("impulse1", 16'h0000, 16'h003F, 1'b0, 1'b0, 5'd0, 16'h0);
        sample_check("impulse2", 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0);

        // Sign handling and negative-zero input
        do_reset();
        write_coef(5'd0, 16'hC000);
        sample_check("sign neg", 16'h2000, 16'h9000, 1'b0, 1'b0, 5'd0, 16'h0);
        sample_check("sign nz",  16'h8000, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0);

        // y = 0.5*x[n] - 0.5*x[n-1]
        tbl[0] = '{16'h0064, 16'h0032};
        tbl[1] = '{16'h0065, 16'h0000};
        tbl[2] = '{16'h0064, 16'h0000};
        tbl[3] = '{16'h8064, 16'h8064};
        tbl[4] = '{16'h8000, 16'h0032};
        tbl[5] = '{16'h7FFF, 16'h3FFF};
        tbl[6] = '{16'hFFFF, 16'hFFFF};
        tbl[7] = '{16'h0003, 16'h4001};
        do_reset();
        write_coef(5'd0, 16'h4000);
        write_coef(5'd1, 16'hC000);
        for (int i = 0; i < 8; i++) begin
            sample_check($sformatf("diff%0d", i), tbl[i].din, tbl[i].exp_out, 1'b0, 1'b0, 5'd0, 16'h0);
        end

        // Coefficient write on the accept edge is used by that computation
        do_reset();
        sample_check("same-edge coef", 16'h0200, 16'h0100, 1'b0, 1'b1, 5'd0, 16'h4000);

        // Back-to-back timing with in_valid held and a dropped coefficient write during MAC
        do_reset();
        write_coef(5'd0, 16'h4000);
        bus.in_data  = 16'h0100;
        bus.in_valid = 1'b1;
        for (int e = 0; e < 110; e++) begin
            if (acc_e.size() == 3 && e >= acc_e[2]) bus.in_valid = 1'b0;
            if (bus.in_valid && bus.in_ready) acc_e.push_back(e + 1);
            if (bus.out_valid) begin
                out_e.push_back(e);
                out_d.push_back(bus.out_data);
            end
            if (acc_e.size() >= 1) begin
                if (e == acc_e[0] + 5) begin
                    bus.coef_we   = 1'b1;
                    bus.coef_addr = 5'd0;
                    bus.coef_data = 16'h7FFF;
                end
                if (e == acc_e[0] + 8) bus.coef_we = 1'b0;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.coef_we  = 1'b0;
        check("timing accepts", 32'(acc_e.size()), 32'd3);
        check("timing outputs", 32'(out_e.size()), 32'd3);
        for (int i = 1; i < acc_e.size(); i++) begin
            check($sformatf("accept period %0d", i), 32'(acc_e[i] - acc_e[i-1]), 32'd32);
        end
        for (int i = 0; i < out_e.size() && i < acc_e.size(); i++) begin
            check($sformatf("latency %0d", i), 32'(out_e[i] - acc_e[i]), 32'd31);
            check($sformatf("busy-write data %0d", i), 32'(out_d[i]), 32'h0080);
        end

        // Full-scale accumulation: saturate or wrap
        do_reset();
        for (int a = 0; a < 30; a++) write_coef(5'(a), 16'h7FFF);
        for (int i = 1; i <= 30; i++) begin
            longint      acc_m;
            longint      mag_m;
            logic [15:0] ed;
            logic        es;
            acc_m = longint'(i) * 64'sd32767 * 64'sd32767;
            mag_m = acc_m >>> 15;
`ifdef FIR_MAC_SAT_EN
            if (mag_m > 64'sd32767) begin
                ed = 16'h7FFF;
                es = 1'b1;
            end else begin
                ed = mag_m[15:0];
                es = 1'b0;
            end
`else
            ed = {1'b0, mag_m[14:0]};
            es = 1'b0;
`endif
            sample_check($sformatf("sat%0d", i), 16'h7FFF, ed, es, 1'b0, 5'd0, 16'h0);
        end

        // Reset during MAC cycle 10
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h7FFF;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid out_data",  32'(bus.out_data),  32'h0);
        check("rstmid out_valid", 32'(bus.out_valid), 32'h0);
        check("rstmid out_sat",   32'(bus.out_sat),   32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rstmid in_ready", 32'(bus.in_ready), 32'h1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) cnt++;
            tick();
        end
        check("rstmid no out_valid", 32'(cnt), 32'd0);
        sample_check("rstmid impulse0", 16'h7FFF, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0);
        sample_check("rstmid impulse1", 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0);
        sample_check("rstmid impulse2", 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_mac_seq.md
FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 SHALL have parameter TAPS, default 30, filter length; legal range 2..256.
REQ-002 SHALL have parameter DW, default 16, sample width in sign-magnitude (MSB sign, magnitude Q0.(DW-1)).
REQ-003 SHALL have parameter CW, default 16, coefficient width in sign-magnitude (MSB sign, magnitude Q0.(CW-1)).
REQ-004 SHALL have ports: clk_slow  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: in_valid  in  1 / in_ready  out  1 / in_data  in  DW, sample handshake.
REQ-007 SHALL have ports: coef_we  in  1 / coef_addr  in  clog2(TAPS) / coef_data  in  CW, coefficient write.
REQ-008 SHALL have ports: out_valid  out  1  one-cycle pulse / out_data  out  DW  sign-magnitude result / out_sat  out  1  saturation flag.

Function
REQ-009 SHALL compute y[n] = sum k=0..TAPS-1 of coef[k]*x[n-k], with one shared multiply-accumulate unit, time-multiplexed.
REQ-010 SHALL use states IDLE, MAC, DONE: IDLE->MAC on in_valid&in_ready; MAC->DONE after TAPS MAC cycles; DONE->IDLE unconditionally.
REQ-011 SHALL drive in_ready=1 only in IDLE; a sample is accepted on the edge where in_valid&in_ready.
REQ-012 SHALL, on accept, write in_data into circular history at wr_ptr and clear the accumulator.
REQ-013 SHALL, in MAC cycle k (k=0..TAPS-1), add coef[k]*hist[(wr_ptr-k) mod TAPS]; the index wraps modulo TAPS for non-power-of-2 TAPS.
REQ-014 SHALL, in DONE, register out_data/out_sat and advance wr_ptr = (wr_ptr+1) mod TAPS.
REQ-015 SHALL assert out_valid for exactly the one cycle after the DONE edge, TAPS+1 edges after the accept edge; in_ready is also 1 in that cycle; sample period is TAPS+2 cycles.
REQ-016 SHALL hold out_data and out_sat unchanged until the next out_valid.
REQ-017 SHALL convert operands to two's complement; product width DW+CW-1; accumulator width DW+CW-1+clog2(TAPS) with no internal overflow.
REQ-018 SHALL form out_data as sign = acc<0, magnitude = |acc| >> (CW-1), truncated toward zero; zero magnitude SHALL carry sign 0.
REQ-019 SHALL treat input or coefficient negative zero (sign=1, magnitude=0) as zero.
REQ-020 SHALL write coef[coef_addr]=coef_data on coef_we only while in_ready=1; writes in MAC/DONE are dropped; addresses >= TAPS are dropped.
REQ-021 SHALL, when an accept and a coefficient write occur on the same edge, perform both; the new coefficient is used by that computation.

Reset
REQ-022 SHALL, while rst=0 (asynchronously), force state IDLE, wr_ptr=0, accumulator=0, all history=0, all coefficients=0, out_valid=0, out_data=0, out_sat=0.
REQ-023 SHALL abandon a computation interrupted by reset mid-MAC, with no out_valid for it; in_ready=1 on the first cycle after release.

Configuration
REQ-024 SHALL honour macro FIR_MAC_SAT_EN: when defined, magnitude > 2^(DW-1)-1 SHALL clamp to 2^(DW-1)-1 with correct sign, and out_sat=1 for that result.
REQ-025 SHALL, when FIR_MAC_SAT_EN is undefined, keep the low DW-1 magnitude bits (wrap), and tie out_sat to 0.

Structure
REQ-026 SHALL take from shared package fir_pkg: state enum, sm2tc/tc2sm conversion functions, accumulator-width and clog2 constants.
REQ-027 SHALL instantiate one sub-module fir_sm_mult (combinational sign-magnitude x sign-magnitude -> two's complement product); history and coefficients are register arrays in the top.

Verification (TAPS=30, DW=CW=16)
REQ-028 SHALL cover reset: rst low -> out_data=16'h0000, out_valid=0, out_sat=0; first cycle after release in_ready=1.
REQ-029 SHALL cover the impulse: coef[1]=16'h0040, then inputs 16'h7FFF, 0, 0 -> outputs 16'h0000, 16'h003F, 16'h0000.
REQ-030 SHALL cover sign handling: coef[0]=16'hC000 (-0.5), input 16'h2000 -> out_data=16'h9000; input 16'h8000 -> out_data=16'h0000.
REQ-031 SHALL cover timing and back-pressure: in_valid held 1 -> accepts every 32 cycles, out_valid exactly 31 cycles after each accept; coef_we during MAC leaves the results unchanged.
REQ-032 SHALL cover saturation: all coef=16'h7FFF, input 16'h7FFF for 30 samples -> with FIR_MAC_SAT_EN, 30th out_data=16'h7FFF and out_sat=1; without the macro, out_sat=0.
REQ-033 SHALL cover reset mid-operation: rst low during MAC cycle 10 -> no out_valid; after release, impulse test repeats with zero history and zero coefficients -> out_data=16'h0000.
